// File: rtl/dwc_upconv_precalc_rchan_pipe.sv
// Read-command precalculation stage for the AXI upsizer: a 2-entry in-order buffer
// that stores each command only in its fully decoded form, so outputs come straight from flops.
module dwc_upconv_precalc_rchan_pipe #(
  parameter int unsigned DATA_WIDTH_MST = 32,
  parameter int unsigned DATA_WIDTH_SLV = 64,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned ADDR_W         = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDR_W-1:0]                     addr_in,
  input  logic [ID_WIDTH-1:0]                   arid_in,
  input  logic [7:0]                            len_in,
  input  logic [2:0]                            size_in,
  input  logic [1:0]                            burst_in,
  input  logic                                  extend_wrap_in,
  input  logic [4:0]                            to_wrap_boundary_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [ADDR_W-1:0]                     addr_beat_out,
  output logic [ID_WIDTH-1:0]                   arid_out,
  output logic [7:0]                            len_out,
  output logic [2:0]                            size_out,
  output logic [4:0]                            to_wrap_boundary_out,
  output logic                                  fixed_flag_out,
  output logic                                  wrap_flag_out,
  output logic                                  len_eq_0_out,
  output logic [$clog2(DATA_WIDTH_SLV/8):0]     lane_mask_out,
  output logic [3:0]                            src_shift_out,
  output logic [$clog2(DATA_WIDTH_SLV/8):0]     src_top_out,
  output logic [ADDR_W-1:0]                     wrap_mask_out,
  output logic                                  err_out,
  output logic [1:0]                            occupancy
);

  localparam int unsigned LogSlv  = $clog2(DATA_WIDTH_SLV / 8);
  localparam int unsigned LogMst  = $clog2(DATA_WIDTH_MST / 8);
  localparam int unsigned LaneW   = LogSlv + 1;
  localparam int unsigned LaneAll = (1 << LogSlv) - 1;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr_beat;
    logic [ID_WIDTH-1:0] arid;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [4:0]          to_wrap_boundary;
    logic                fixed_flag;
    logic                wrap_flag;
    logic                len_eq_0;
    logic [LogSlv:0]     lane_mask;
    logic [3:0]          src_shift;
    logic [LogSlv:0]     src_top;
    logic [ADDR_W-1:0]   wrap_mask;
    logic                err;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  entry_t calc;
  logic   wrap_len_ok;
  logic   size_fits;

  always_comb begin
    calc                  = '0;
    size_fits             = (32'(size_in) <= LogSlv);
    wrap_len_ok           = (len_in == 8'd1) || (len_in == 8'd3) || (len_in == 8'd7) ||
                            (len_in == 8'd15);
    calc.addr_beat        = addr_in >> size_in;
    calc.arid             = arid_in;
    calc.len              = len_in;
    calc.size             = size_in;
    calc.to_wrap_boundary = to_wrap_boundary_in;
    calc.fixed_flag       = (burst_in == 2'b00);
    calc.wrap_flag        = (burst_in == 2'b10) && extend_wrap_in;
    calc.len_eq_0         = (len_in == 8'd0);
    // Sizes wider than the slave bus have no meaningful lane geometry.
    if (size_fits) begin
      calc.lane_mask = LaneW'(LaneAll >> size_in);
      calc.src_shift = 4'(LogSlv - 32'(size_in));
      calc.src_top   = LaneW'((32'd1 << (LogSlv - 32'(size_in))) - 32'd1);
    end
    if ((burst_in == 2'b10) && wrap_len_ok) begin
      calc.wrap_mask = ADDR_W'(((32'(len_in) + 32'd1) << size_in) - 32'd1);
    end
    calc.err = (32'(size_in) > LogMst) || (burst_in == 2'b11) ||
               ((burst_in == 2'b10) && !wrap_len_ok);
  end

  state_e state_q, state_d;
  entry_t head_q, head_d, tail_q, tail_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          head_d  = calc;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && pop) begin
          head_d = calc;
        end else if (push) begin
          tail_d  = calc;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign occupancy            = (state_q == StFull) ? 2'd2 : ((state_q == StOne) ? 2'd1 : 2'd0);
  assign addr_beat_out        = head_q.addr_beat;
  assign arid_out             = head_q.arid;
  assign len_out              = head_q.len;
  assign size_out             = head_q.size;
  assign to_wrap_boundary_out = head_q.to_wrap_boundary;
  assign fixed_flag_out       = head_q.fixed_flag;
  assign wrap_flag_out        = head_q.wrap_flag;
  assign len_eq_0_out         = head_q.len_eq_0;
  assign lane_mask_out        = head_q.lane_mask;
  assign src_shift_out        = head_q.src_shift;
  assign src_top_out          = head_q.src_top;
  assign wrap_mask_out        = head_q.wrap_mask;
  assign err_out              = head_q.err;

endmodule

// File: tb/tb_dwc_upconv_precalc_rchan_pipe.sv
// Bench for the read-command precalc buffer: directed scenarios plus a randomized run
// against a queue-based reference model; a second instance covers a 256-bit slave bus.
module tb_dwc_upconv_precalc_rchan_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [6:0] addr_in;
  logic [3:0] arid_in;
  logic [7:0] len_in;
  logic [2:0] size_in;
  logic [1:0] burst_in;
  logic       extend_wrap_in;
  logic [4:0] to_wrap_boundary_in;
  logic [6:0] addr_beat_out, wrap_mask_out;
  logic [3:0] arid_out, lane_mask_out, src_shift_out, src_top_out;
  logic [7:0] len_out;
  logic [2:0] size_out;
  logic [4:0] to_wrap_boundary_out;
  logic       fixed_flag_out, wrap_flag_out, len_eq_0_out, err_out;
  logic [1:0] occupancy;

  // Wide-slave instance: shares command fields, has its own valid and size.
  logic       w_in_valid, w_in_ready, w_out_valid, w_fixed, w_wrapf, w_leq0, w_err;
  logic [2:0] w_size_in, w_size_out;
  logic [6:0] w_addr_beat, w_wrap_mask;
  logic [3:0] w_arid, w_src_shift;
  logic [7:0] w_len;
  logic [4:0] w_twb;
  logic [5:0] w_lane_mask, w_src_top;
  logic [1:0] w_occ;

  int checks = 0;
  int failures = 0;

  dwc_upconv_precalc_rchan_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .addr_in(addr_in), .arid_in(arid_in), .len_in(len_in), .size_in(size_in),
    .burst_in(burst_in), .extend_wrap_in(extend_wrap_in),
    .to_wrap_boundary_in(to_wrap_boundary_in), .out_valid(out_valid), .out_ready(out_ready),
    .addr_beat_out(addr_beat_out), .arid_out(arid_out), .len_out(len_out),
    .size_out(size_out), .to_wrap_boundary_out(to_wrap_boundary_out),
    .fixed_flag_out(fixed_flag_out), .wrap_flag_out(wrap_flag_out),
    .len_eq_0_out(len_eq_0_out), .lane_mask_out(lane_mask_out), .src_shift_out(src_shift_out),
    .src_top_out(src_top_out), .wrap_mask_out(wrap_mask_out), .err_out(err_out),
    .occupancy(occupancy)
  );

  dwc_upconv_precalc_rchan_pipe #(
    .DATA_WIDTH_MST(32), .DATA_WIDTH_SLV(256), .ID_WIDTH(4), .ADDR_W(7)
  ) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .addr_in(addr_in), .arid_in(arid_in), .len_in(len_in), .size_in(w_size_in),
    .burst_in(burst_in), .extend_wrap_in(extend_wrap_in),
    .to_wrap_boundary_in(to_wrap_boundary_in), .out_valid(w_out_valid), .out_ready(out_ready),
    .addr_beat_out(w_addr_beat), .arid_out(w_arid), .len_out(w_len), .size_out(w_size_out),
    .to_wrap_boundary_out(w_twb), .fixed_flag_out(w_fixed), .wrap_flag_out(w_wrapf),
    .len_eq_0_out(w_leq0), .lane_mask_out(w_lane_mask), .src_shift_out(w_src_shift),
    .src_top_out(w_src_top), .wrap_mask_out(w_wrap_mask), .err_out(w_err), .occupancy(w_occ)
  );

  typedef struct packed {
    logic [6:0] ab;
    logic [3:0] id;
    logic [7:0] len;
    logic [2:0] size;
    logic [4:0] twb;
    logic       fx;
    logic       wf;
    logic       l0;
    logic [3:0] lane;
    logic [3:0] shift;
    logic [3:0] top;
    logic [6:0] wm;
    logic       err;
  } ent_t;

  ent_t exp_e;
  ent_t model_q[$];

  // Reference decode for a 32-bit master / 64-bit slave bus (8-byte slave beats).
  function automatic ent_t model(input logic [6:0] a, input logic [3:0] id, input logic [7:0] len,
                                 input logic [2:0] sz, input logic [1:0] b, input logic ext,
                                 input logic [4:0] twb);
    int   ls = 3;
    int   lm = 2;
    int   n  = int'(sz);
    bit   lw;
    ent_t e;
    e      = '0;
    e.ab   = 7'(int'(a) / (1 << n));
    e.id   = id;
    e.len  = len;
    e.size = sz;
    e.twb  = twb;
    e.fx   = (b == 2'd0);
    e.wf   = (b == 2'd2) && ext;
    e.l0   = (len == 8'd0);
    if (n <= ls) begin
      e.lane  = 4'(((1 << ls) - 1) / (1 << n));
      e.shift = 4'(ls - n);
      e.top   = 4'((1 << (ls - n)) - 1);
    end
    lw    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    e.wm  = (b == 2'd2 && lw) ? 7'((int'(len) + 1) * (1 << n) - 1) : 7'd0;
    e.err = (n > lm) || (b == 2'd3) || (b == 2'd2 && !lw);
    return e;
  endfunction

  function automatic ent_t obs();
    ent_t o;
    o = {addr_beat_out, arid_out, len_out, size_out, to_wrap_boundary_out, fixed_flag_out,
         wrap_flag_out, len_eq_0_out, lane_mask_out, src_shift_out, src_top_out, wrap_mask_out,
         err_out};
    return o;
  endfunction

  task automatic set_cmd(input logic [6:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] b, input logic ext,
                         input logic [4:0] twb);
    addr_in = a; arid_in = id; len_in = len; size_in = sz; burst_in = b;
    extend_wrap_in = ext; to_wrap_boundary_in = twb;
    exp_e = model(a, id, len, sz, b, ext, twb);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || obs() !== ent_t'(0)) begin
      failures++;
      $display("FAIL reset_state: occ=%0d ov=%0b ir=%0b data=%h, want 0/0/0/0",
               occupancy, out_valid, in_ready, obs());
    end
    #10 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: in_ready=%0b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_edge: in_ready=%0b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_cmd(7'h2C, 4'd3, 8'd3, 3'd2, 2'b01, 1'b0, 5'd4);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs() !== exp_e) begin
      failures++;
      $display("FAIL basic_entry: ov=%0b got=%h want ov=1 %h", out_valid, obs(), exp_e);
    end
    checks++;
    if (addr_beat_out !== 7'h0B || lane_mask_out !== 4'd1 || src_shift_out !== 4'd1 ||
        src_top_out !== 4'd1 || len_eq_0_out !== 1'b0 || err_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_fields: ab=%h lane=%0d sh=%0d top=%0d l0=%0b err=%0b want 0b/1/1/1/0/0",
               addr_beat_out, lane_mask_out, src_shift_out, src_top_out, len_eq_0_out, err_out);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pop: out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    set_cmd(7'h14, 4'd5, 8'd7, 3'd2, 2'b10, 1'b1, 5'd3);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (wrap_mask_out !== 7'h1F || wrap_flag_out !== 1'b1 || err_out !== 1'b0 || obs() !== exp_e) begin
      failures++;
      $display("FAIL wrap_len7: wm=%h wf=%0b err=%0b got=%h want 1f/1/0 %h",
               wrap_mask_out, wrap_flag_out, err_out, obs(), exp_e);
    end
    set_cmd(7'h14, 4'd6, 8'd5, 3'd2, 2'b10, 1'b1, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wrap_mask_out !== 7'h00 || err_out !== 1'b1 || arid_out !== 4'd6) begin
      failures++;
      $display("FAIL wrap_len5: wm=%h err=%0b id=%0d want 0/1/6", wrap_mask_out, err_out, arid_out);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    ent_t ea, eb;
    out_ready = 1'b0;
    set_cmd(7'h11, 4'd1, 8'd0, 3'd0, 2'b00, 1'b0, 5'd0); ea = exp_e;
    in_valid = 1'b1;
    @(negedge clk);
    set_cmd(7'h22, 4'd2, 8'd1, 3'd1, 2'b01, 1'b0, 5'd1); eb = exp_e;
    @(negedge clk);
    set_cmd(7'h33, 4'd3, 8'd2, 3'd1, 2'b01, 1'b0, 5'd2);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || obs() !== ea) begin
      failures++;
      $display("FAIL full_state: occ=%0d ir=%0b got=%h want 2/0 %h", occupancy, in_ready, obs(), ea);
    end
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd2 || obs() !== ea) begin
      failures++;
      $display("FAIL full_hold: occ=%0d got=%h want 2 %h", occupancy, obs(), ea);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || obs() !== eb) begin
      failures++;
      $display("FAIL full_pop_no_push: occ=%0d ir=%0b got=%h want 1/1 %h",
               occupancy, in_ready, obs(), eb);
    end
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_c_absent: occ=%0d ov=%0b want 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_cmd(7'h05, 4'd0, 8'd1, 3'd0, 2'b01, 1'b0, 5'd0);
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      set_cmd(7'(i * 3), 4'(i), 8'(i), 3'(i % 4), 2'b01, 1'b0, 5'(i));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || occupancy !== 2'd1 || obs() !== exp_e) begin
        failures++;
        $display("FAIL b2b_%0d: ov=%0b occ=%0d got=%h want 1/1 %h",
                 i, out_valid, occupancy, obs(), exp_e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 2'd0) begin
      failures++;
      $display("FAIL b2b_drain: occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_cmd(7'h01, 4'd9, 8'd2, 3'd1, 2'b01, 1'b0, 5'd0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || obs() !== ent_t'(0)) begin
      failures++;
      $display("FAIL mid_reset: ov=%0b occ=%0d ir=%0b data=%h want 0/0/0/0",
               out_valid, occupancy, in_ready, obs());
    end
    #4 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_release: ir=%0b occ=%0d want 1/0", in_ready, occupancy);
    end
    set_cmd(7'h7F, 4'd12, 8'd15, 3'd3, 2'b10, 1'b0, 5'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || obs() !== exp_e) begin
      failures++;
      $display("FAIL mid_reset_push: ov=%0b got=%h want 1 %h", out_valid, obs(), exp_e);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (occupancy !== 2'(model_q.size()) || in_ready !== (model_q.size() < 2) ||
          out_valid !== (model_q.size() != 0) ||
          (model_q.size() != 0 && obs() !== model_q[0])) begin
        failures++;
        $display("FAIL rand_cycle_%0d: occ=%0d ir=%0b got=%h want occ=%0d head=%h",
                 c, occupancy, in_ready, obs(), model_q.size(),
                 (model_q.size() != 0) ? model_q[0] : ent_t'(0));
      end
      set_cmd(7'($urandom), 4'($urandom), ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 16))
              : 8'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_ready && model_q.size() != 0) begin
        if (in_valid && model_q.size() < 2) begin
          void'(model_q.pop_front());
          model_q.push_back(exp_e);
        end else begin
          void'(model_q.pop_front());
        end
      end else if (in_valid && model_q.size() < 2) begin
        model_q.push_back(exp_e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wide();
    set_cmd(7'h40, 4'd1, 8'd0, 3'd0, 2'b01, 1'b0, 5'd0);
    out_ready = 1'b1; w_in_valid = 1'b1; w_size_in = 3'd5;
    @(negedge clk);
    w_size_in = 3'd4;
    checks++;
    if (w_out_valid !== 1'b1 || w_lane_mask !== 6'd0 || w_src_shift !== 4'd0 ||
        w_src_top !== 6'd0 || w_err !== 1'b1) begin
      failures++;
      $display("FAIL wide_size5: ov=%0b lane=%0d sh=%0d top=%0d err=%0b want 1/0/0/0/1",
               w_out_valid, w_lane_mask, w_src_shift, w_src_top, w_err);
    end
    @(negedge clk);
    w_size_in = 3'd6;
    checks++;
    if (w_lane_mask !== 6'd1 || w_src_shift !== 4'd1 || w_src_top !== 6'd1 ||
        w_addr_beat !== 7'h04) begin
      failures++;
      $display("FAIL wide_size4: lane=%0d sh=%0d top=%0d ab=%h want 1/1/1/04",
               w_lane_mask, w_src_shift, w_src_top, w_addr_beat);
    end
    @(negedge clk);
    w_in_valid = 1'b0;
    checks++;
    if (w_err !== 1'b1 || w_lane_mask !== 6'd0 || w_src_shift !== 4'd0 || w_src_top !== 6'd0) begin
      failures++;
      $display("FAIL wide_size6: err=%0b lane=%0d sh=%0d top=%0d want 1/0/0/0",
               w_err, w_lane_mask, w_src_shift, w_src_top);
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; w_in_valid = 1'b0; w_size_in = 3'd0;
    set_cmd(7'd0, 4'd0, 8'd0, 3'd0, 2'd0, 1'b0, 5'd0);
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
